// File: rtl/aes_enc_pkg.sv
// ============================================================================
// Package : aes_enc_pkg
// Brief   : Shared state encoding, legal round counts and round-index width
//           for the AES encryption controller.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package aes_enc_pkg;

    localparam int unsigned IDX_W     = 4;
    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARK0  = 3'd1,
        S_SUB   = 3'd2,
        S_ROW   = 3'd3,
        S_COL   = 3'd4,
        S_ARK   = 3'd5,
        S_FINAL = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    function automatic logic nr_is_legal(input int unsigned nr);
        return (nr == NR_AES128) || (nr == NR_AES192) || (nr == NR_AES256);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_enc_round_counter.sv
// ============================================================================
// Module : aes_enc_round_counter
// Brief  : Round index register with clear, saturating increment and a
//          compare-to-NR flag used by the controller FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aes_enc_round_counter
    import aes_enc_pkg::*;
#(
    parameter int unsigned NR = NR_AES128
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             incr_i,
    output logic [IDX_W-1:0] count_o,
    output logic             at_last_o
);

    localparam logic [IDX_W-1:0] C_NR = IDX_W'(NR);

    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] count_d;

    // Increment saturates at NR so the index can never run past the key schedule.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (incr_i && (count_q != C_NR)) begin
            count_d = count_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign at_last_o = (count_q == C_NR);

endmodule

`default_nettype wire

// File: rtl/aes_enc_control.sv
// ============================================================================
// Module : aes_enc_control
// Brief  : Round-sequencing FSM for an iterative AES encryption datapath.
//          Optional abort input enabled by macro AES_ENC_CTRL_ABORT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aes_enc_control
    import aes_enc_pkg::*;
#(
    parameter int unsigned NR = NR_AES128
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             encrypt,
`ifdef AES_ENC_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             init,
    output logic             isRound0,
    output logic             isLastRound,
    output logic             en_round_out,
    output logic             en_reg_sub_out,
    output logic             en_reg_row_out,
    output logic             en_reg_col_out,
    output logic             en_Dout,
    output logic [IDX_W-1:0] round_idx,
    output logic             busy,
    output logic             done
);

    state_t state_q;
    state_t state_d;

    logic   cnt_clear;
    logic   cnt_incr;
    logic   cnt_last;
    logic   abort_req;

`ifdef AES_ENC_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    aes_enc_round_counter #(
        .NR        (NR)
    ) u_round_counter (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (cnt_clear),
        .incr_i    (cnt_incr),
        .count_o   (round_idx),
        .at_last_o (cnt_last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        init           = 1'b0;
        isRound0       = 1'b0;
        isLastRound    = 1'b0;
        en_round_out   = 1'b0;
        en_reg_sub_out = 1'b0;
        en_reg_row_out = 1'b0;
        en_reg_col_out = 1'b0;
        en_Dout        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        cnt_clear      = 1'b0;
        cnt_incr       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (encrypt) begin
                    // Mealy init is gated by reset so nothing toggles while it is held.
                    init      = reset;
                    cnt_clear = 1'b1;
                    state_d   = S_ARK0;
                end
            end
            S_ARK0: begin
                busy         = 1'b1;
                isRound0     = 1'b1;
                en_round_out = 1'b1;
                cnt_incr     = 1'b1;
                state_d      = S_SUB;
            end
            S_SUB: begin
                busy           = 1'b1;
                en_reg_sub_out = 1'b1;
                state_d        = S_ROW;
            end
            S_ROW: begin
                busy           = 1'b1;
                en_reg_row_out = 1'b1;
                state_d        = cnt_last ? S_FINAL : S_COL;
            end
            S_COL: begin
                busy           = 1'b1;
                en_reg_col_out = 1'b1;
                state_d        = S_ARK;
            end
            S_ARK: begin
                busy         = 1'b1;
                en_round_out = 1'b1;
                cnt_incr     = 1'b1;
                state_d      = S_SUB;
            end
            S_FINAL: begin
                busy        = 1'b1;
                isLastRound = 1'b1;
                en_Dout     = 1'b1;
                state_d     = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_req && busy) begin
            state_d   = S_IDLE;
            cnt_clear = 1'b1;
            cnt_incr  = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_enc_control.sv
// ============================================================================
// Module : tb_aes_enc_control
// Brief  : Self-checking bench for aes_enc_control (NR=10 and NR=14 instances).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_aes_enc_control;

    localparam int NRA = 10;
    localparam int NRB = 14;

    // Output vector layout:
    // [13]init [12]isRound0 [11]isLastRound [10]en_round_out [9]en_reg_sub_out
    // [8]en_reg_row_out [7]en_reg_col_out [6]en_Dout [5]busy [4]done [3:0]round_idx
    typedef struct {
        int          off;
        logic [13:0] exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        rst_a, enc_a, abort_a;
    logic        rst_b, enc_b, abort_b;
    wire  [13:0] out_a;
    wire  [13:0] out_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pos_a    = -1;
    int pos_b    = -1;
    int col_a    = 0;
    int col_b    = 0;
    int done_a   = 0;
    int dout_a[$];
    int dout_b[$];

    always #5 clock = ~clock;

    aes_enc_control #(.NR(NRA)) u_dut_a (
        .clock          (clock),
        .reset          (rst_a),
        .encrypt        (enc_a),
`ifdef AES_ENC_CTRL_ABORT_EN
        .abort          (abort_a),
`endif
        .init           (out_a[13]),
        .isRound0       (out_a[12]),
        .isLastRound    (out_a[11]),
        .en_round_out   (out_a[10]),
        .en_reg_sub_out (out_a[9]),
        .en_reg_row_out (out_a[8]),
        .en_reg_col_out (out_a[7]),
        .en_Dout        (out_a[6]),
        .round_idx      (out_a[3:0]),
        .busy           (out_a[5]),
        .done           (out_a[4])
    );

    aes_enc_control #(.NR(NRB)) u_dut_b (
        .clock          (clock),
        .reset          (rst_b),
        .encrypt        (enc_b),
`ifdef AES_ENC_CTRL_ABORT_EN
        .abort          (abort_b),
`endif
        .init           (out_b[13]),
        .isRound0       (out_b[12]),
        .isLastRound    (out_b[11]),
        .en_round_out   (out_b[10]),
        .en_reg_sub_out (out_b[9]),
        .en_reg_row_out (out_b[8]),
        .en_reg_col_out (out_b[7]),
        .en_Dout        (out_b[6]),
        .round_idx      (out_b[3:0]),
        .busy           (out_b[5]),
        .done           (out_b[4])
    );

    // Reference model: pos = -1 idle, -2 done, k>=1 = k cycles after encrypt accepted.
    function automatic logic [13:0] model_out(int pos, int nr, logic enc, logic rstn);
        logic [13:0] e;
        int          r;
        int          ph;
        e = '0;
        if (!rstn) return e;
        if (pos < 0) begin
            e[13]  = enc;
            e[4]   = (pos == -2);
            e[3:0] = (pos == -2) ? nr[3:0] : 4'd0;
        end else begin
            e[5] = 1'b1;
            if (pos == 1) begin
                e[12] = 1'b1;
                e[10] = 1'b1;
            end else if (pos == 4 * nr) begin
                e[11]  = 1'b1;
                e[6]   = 1'b1;
                e[3:0] = nr[3:0];
            end else begin
                r      = (pos - 2) / 4 + 1;
                ph     = (pos - 2) % 4;
                e[3:0] = r[3:0];
                case (ph)
                    0:       e[9]  = 1'b1;
                    1:       e[8]  = 1'b1;
                    2:       e[7]  = 1'b1;
                    default: e[10] = 1'b1;
                endcase
            end
        end
        return e;
    endfunction

    function automatic int model_next(int pos, int nr, logic enc, logic rstn, logic ab);
        if (!rstn) return -1;
        if (pos > 0 && ab) return -1;
        if (pos < 0) return enc ? 1 : pos;
        if (pos == 4 * nr) return -2;
        return pos + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic sample();
        #1;
        check("model_a", {18'd0, out_a}, {18'd0, model_out(pos_a, NRA, enc_a, rst_a)});
        check("model_b", {18'd0, out_b}, {18'd0, model_out(pos_b, NRB, enc_b, rst_b)});
        if (out_a[6] === 1'b1) dout_a.push_back(cyc);
        if (out_b[6] === 1'b1) dout_b.push_back(cyc);
        if (out_a[7] === 1'b1) col_a++;
        if (out_b[7] === 1'b1) col_b++;
        if (out_a[4] === 1'b1) done_a++;
    endtask

    task automatic advance();
        @(posedge clock);
        pos_a = model_next(pos_a, NRA, enc_a, rst_a, abort_a);
        pos_b = model_next(pos_b, NRB, enc_b, rst_b, abort_b);
        cyc++;
        @(negedge clock);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    vec_t tbl[$];
    int   t0;
    int   ti;

    initial begin
        rst_a = 1'b0; enc_a = 1'b0; abort_a = 1'b0;
        rst_b = 1'b0; enc_b = 1'b0; abort_b = 1'b0;
        @(negedge clock);

        // Reset state
        sample();
        check("reset_out_a", {18'd0, out_a}, 32'd0);
        check("reset_out_b", {18'd0, out_b}, 32'd0);
        advance();
        enc_a = 1'b1;
        sample();
        check("reset_init_gated", {31'd0, out_a[13]}, 32'd0);
        advance();
        enc_a = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        run_cycles(2);

        // Single operation, NR=10, checked against a table of cycle offsets
        tbl.push_back('{0,  14'h2000});
        tbl.push_back('{1,  14'h1420});
        tbl.push_back('{2,  14'h0221});
        tbl.push_back('{3,  14'h0121});
        tbl.push_back('{4,  14'h00A1});
        tbl.push_back('{5,  14'h0421});
        tbl.push_back('{6,  14'h0222});
        tbl.push_back('{37, 14'h0429});
        tbl.push_back('{38, 14'h022A});
        tbl.push_back('{39, 14'h012A});
        tbl.push_back('{40, 14'h086A});
        tbl.push_back('{41, 14'h001A});
        tbl.push_back('{45, 14'h001A});
        col_a = 0;
        ti    = 0;
        for (int off = 0; off <= 45; off++) begin
            enc_a = (off == 0);
            sample();
            if (ti < tbl.size() && tbl[ti].off == off) begin
                check($sformatf("tbl_off%0d", off), {18'd0, out_a}, {18'd0, tbl[ti].exp});
                ti++;
            end
            advance();
        end
        check("col_pulses_nr10", col_a, 9);

        // Held encrypt: restart from S_DONE, back-to-back
        dout_a.delete();
        t0    = cyc;
        enc_a = 1'b1;
        run_cycles(90);
        enc_a = 1'b0;
        check("restart_dout_count", dout_a.size(), 2);
        if (dout_a.size() >= 2) begin
            check("restart_dout1", dout_a[0], t0 + 40);
            check("restart_dout2", dout_a[1], t0 + 81);
        end
        run_cycles(45);

        // Reset mid-operation
        enc_a = 1'b1;
        run_cycles(1);
        enc_a = 1'b0;
        run_cycles(44);
        dout_a.delete();
        t0    = cyc;
        enc_a = 1'b1;
        run_cycles(1);
        enc_a = 1'b0;
        run_cycles(19);
        rst_a = 1'b0;
        sample();
        check("midreset_out", {18'd0, out_a}, 32'd0);
        advance();
        run_cycles(1);
        rst_a = 1'b1;
        run_cycles(30);
        check("midreset_no_dout", dout_a.size(), 0);
        t0    = cyc;
        enc_a = 1'b1;
        run_cycles(1);
        enc_a = 1'b0;
        run_cycles(44);
        check("fresh_dout_count", dout_a.size(), 1);
        if (dout_a.size() >= 1) check("fresh_dout_cycle", dout_a[0], t0 + 40);

        // NR=14 instance
        dout_b.delete();
        col_b = 0;
        t0    = cyc;
        enc_b = 1'b1;
        run_cycles(1);
        enc_b = 1'b0;
        run_cycles(60);
        check("nr14_dout_count", dout_b.size(), 1);
        if (dout_b.size() >= 1) check("nr14_dout_cycle", dout_b[0], t0 + 56);
        check("nr14_col_pulses", col_b, 13);
        check("nr14_done", {31'd0, out_b[4]}, 32'd1);

`ifdef AES_ENC_CTRL_ABORT_EN
        // Abort mid-operation
        dout_a.delete();
        done_a = 0;
        enc_a  = 1'b1;
        run_cycles(1);
        enc_a  = 1'b0;
        run_cycles(9);
        abort_a = 1'b1;
        run_cycles(1);
        abort_a = 1'b0;
        sample();
        check("abort_idle_busy", {31'd0, out_a[5]}, 32'd0);
        advance();
        run_cycles(50);
        check("abort_no_done", done_a, 0);
        check("abort_no_dout", dout_a.size(), 0);
`endif

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            logic e;
            logic r;
            logic ab;
            e  = ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 199) != 0);
            ab = 1'b0;
`ifdef AES_ENC_CTRL_ABORT_EN
            ab = ($urandom_range(0, 63) == 0);
`endif
            enc_a = e; enc_b = e;
            rst_a = r; rst_b = r;
            abort_a = ab; abort_b = ab;
            run_cycles(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
